// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream in, RAM write port and CPU release out
interface program_loader_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  start;
  logic                  bypass;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_wdata;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output start, bypass, in_valid, in_data,
    input  in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, bypass, in_valid, in_data,
    output in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a length-prefixed byte stream into RAM at ORIGIN, then releases the CPU
module program_loader #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] ORIGIN     = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  program_loader_if.slave   bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_FLUSH, S_DONE, S_ERROR
  } state_t;

  // Wide enough that ORIGIN + any 16-bit length cannot wrap.
  localparam int SUM_W = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;
  localparam logic [SUM_W-1:0] ADDR_SPAN = SUM_W'(1) << ADDR_WIDTH;

  state_t                state;
  logic [7:0]            len_lo;
  logic [15:0]           remaining;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic                  accept;
  logic [15:0]           len_full;
  logic [SUM_W-1:0]      end_addr;
  logic                  overflow;

  assign accept   = bus.in_valid && bus.in_ready;
  assign len_full = {bus.in_data, len_lo};
  assign end_addr = SUM_W'(ORIGIN) + SUM_W'(len_full);
  assign overflow = end_addr > ADDR_SPAN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      len_lo        <= 8'h00;
      remaining     <= 16'h0000;
      next_addr     <= ORIGIN;
      bus.in_ready  <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= ORIGIN;
      bus.ram_wdata <= 8'h00;
      bus.cpu_hold  <= 1'b1;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.ram_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state        <= S_LEN_LO;
            bus.in_ready <= 1'b1;
          end else if (bus.bypass) begin
            state        <= S_DONE;
            bus.done     <= 1'b1;
            bus.cpu_hold <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_lo <= bus.in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            remaining <= len_full;
            next_addr <= ORIGIN;
            if (overflow) begin
              state        <= S_ERROR;
              bus.in_ready <= 1'b0;
              bus.error    <= 1'b1;
            end else if (len_full == 16'h0000) begin
              state        <= S_DONE;
              bus.in_ready <= 1'b0;
              bus.done     <= 1'b1;
              bus.cpu_hold <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            bus.ram_we    <= 1'b1;
            bus.ram_addr  <= next_addr;
            bus.ram_wdata <= bus.in_data;
            next_addr     <= next_addr + 1'b1;
            remaining     <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state        <= S_FLUSH;
              bus.in_ready <= 1'b0;
            end
          end
        end
        // The final strobe is on the bus during this cycle.
        S_FLUSH: begin
          state        <= S_DONE;
          bus.done     <= 1'b1;
          bus.cpu_hold <= 1'b0;
        end
        S_DONE: begin
          if (bus.start) begin
            state        <= S_LEN_LO;
            bus.in_ready <= 1'b1;
            bus.done     <= 1'b0;
            bus.cpu_hold <= 1'b1;
          end
        end
        S_ERROR: begin
          state <= S_ERROR;
        end
        default: begin
          state        <= S_IDLE;
          bus.in_ready <= 1'b0;
          bus.done     <= 1'b0;
          bus.cpu_hold <= 1'b1;
          bus.error    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed and randomized loads against a stream-format reference model
module tb_program_loader;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(AW)) a_if ();
  program_loader_if #(.ADDR_WIDTH(AW)) b_if ();

  program_loader #(.ADDR_WIDTH(AW), .ORIGIN(16'h0000)) dut_a (.clk(clk), .reset(rst_a), .bus(a_if.slave));
  program_loader #(.ADDR_WIDTH(AW), .ORIGIN(16'hFFF0)) dut_b (.clk(clk), .reset(rst_b), .bus(b_if.slave));

  typedef struct { int w; int cyc; int addr; int data; } wr_t;
  wr_t wr_q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (a_if.ram_we === 1'b1) wr_q.push_back('{0, cyc, int'(a_if.ram_addr), int'(a_if.ram_wdata)});
    if (b_if.ram_we === 1'b1) wr_q.push_back('{1, cyc, int'(b_if.ram_addr), int'(b_if.ram_wdata)});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int origin_of(input int w);
    return (w == 0) ? 0 : 32'hFFF0;
  endfunction
  function automatic logic rdy(input int w);
    return (w == 0) ? a_if.in_ready : b_if.in_ready;
  endfunction
  function automatic logic we_of(input int w);
    return (w == 0) ? a_if.ram_we : b_if.ram_we;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 0) ? a_if.done : b_if.done;
  endfunction
  function automatic logic hold_of(input int w);
    return (w == 0) ? a_if.cpu_hold : b_if.cpu_hold;
  endfunction
  function automatic logic err_of(input int w);
    return (w == 0) ? a_if.error : b_if.error;
  endfunction

  task automatic drive(input int w, input logic v, input logic [7:0] d);
    if (w == 0) begin a_if.in_valid = v; a_if.in_data = d; end
    else begin b_if.in_valid = v; b_if.in_data = d; end
  endtask
  task automatic set_start(input int w, input logic v);
    if (w == 0) a_if.start = v; else b_if.start = v;
  endtask
  task automatic set_bypass(input int w, input logic v);
    if (w == 0) a_if.bypass = v; else b_if.bypass = v;
  endtask
  task automatic pulse_start(input int w);
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
  endtask

  // Called on a negedge; returns on the negedge after the byte was taken.
  task automatic send(input int w, input logic [7:0] d);
    int n = 0;
    drive(w, 1'b1, d);
    while (rdy(w) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", rdy(w), 1'b1);
    @(negedge clk);
    drive(w, 1'b0, 8'($urandom));
  endtask

  task automatic check_writes(input string tag, input int w, input int ea[$], input int ed[$]);
    wr_t got[$];
    foreach (wr_q[i]) if (wr_q[i].w == w) got.push_back(wr_q[i]);
    check({tag, "_count"}, got.size(), ea.size());
    for (int i = 0; i < ea.size() && i < got.size(); i++) begin
      check({tag, "_addr"}, got[i].addr, ea[i]);
      check({tag, "_data"}, got[i].data, ed[i]);
    end
  endtask

  // Reference: payload byte k lands at origin+k unless origin+len exceeds the address space.
  task automatic run_load(input int w, input int len, input int maxgap);
    int org = origin_of(w);
    logic [7:0] pay[$];
    int ea[$];
    int ed[$];
    bit ovf = (org + len) > (1 << AW);
    for (int k = 0; k < len; k++) pay.push_back(8'($urandom));
    if (!ovf) for (int k = 0; k < len; k++) begin ea.push_back(org + k); ed.push_back(int'(pay[k])); end
    wr_q.delete();
    pulse_start(w);
    check("start_ready", rdy(w), 1'b1);
    check("start_hold", hold_of(w), 1'b1);
    check("start_done", done_of(w), 1'b0);
    send(w, 8'(len));
    send(w, 8'(len >> 8));
    if (!ovf) begin
      for (int k = 0; k < len; k++) begin
        if (k > 0) repeat ($urandom_range(maxgap, 0)) @(negedge clk);
        send(w, pay[k]);
      end
    end
    repeat (3) @(negedge clk);
    check("load_done", done_of(w), !ovf);
    check("load_error", err_of(w), ovf);
    check("load_hold", hold_of(w), ovf);
    check("load_ready", rdy(w), 1'b0);
    check_writes("load", w, ea, ed);
  endtask

  initial begin
    int ea[$];
    int ed[$];
    logic [7:0] p0, p1;
    for (int w = 0; w < 2; w++) begin
      drive(w, 1'b0, 8'h00);
      set_start(w, 1'b0);
      set_bypass(w, 1'b0);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", a_if.in_ready, 1'b0);
    check("rst_we", a_if.ram_we, 1'b0);
    check("rst_addr", a_if.ram_addr, 16'h0000);
    check("rst_wdata", a_if.ram_wdata, 8'h00);
    check("rst_hold", a_if.cpu_hold, 1'b1);
    check("rst_done", a_if.done, 1'b0);
    check("rst_error", a_if.error, 1'b0);
    check("rst_addr_b", b_if.ram_addr, 16'hFFF0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b1, 8'h55);
    repeat (2) @(negedge clk);
    drive(0, 1'b0, 8'h00);
    check("idle_hold", a_if.cpu_hold, 1'b1);
    check("idle_ready", a_if.in_ready, 1'b0);

    // 03,00,AA,BB,CC back to back
    wr_q.delete();
    pulse_start(0);
    send(0, 8'h03); send(0, 8'h00); send(0, 8'hAA); send(0, 8'hBB); send(0, 8'hCC);
    check("t1_flush_we", a_if.ram_we, 1'b1);
    check("t1_flush_done", a_if.done, 1'b0);
    @(negedge clk);
    check("t1_done", a_if.done, 1'b1);
    check("t1_hold", a_if.cpu_hold, 1'b0);
    ea = {0, 1, 2};
    ed = {8'hAA, 8'hBB, 8'hCC};
    check_writes("t1", 0, ea, ed);
    if (wr_q.size() == 3) begin
      check("t1_cyc1", wr_q[1].cyc, wr_q[0].cyc + 1);
      check("t1_cyc2", wr_q[2].cyc, wr_q[0].cyc + 2);
    end

    // zero length, restarted from DONE
    wr_q.delete();
    pulse_start(0);
    check("t2_hold", a_if.cpu_hold, 1'b1);
    check("t2_done0", a_if.done, 1'b0);
    send(0, 8'h00); send(0, 8'h00);
    check("t2_done", a_if.done, 1'b1);
    repeat (2) @(negedge clk);
    check("t2_nowrites", wr_q.size(), 0);

    // gaps in DATA; start and bypass must be ignored there
    wr_q.delete();
    pulse_start(0);
    send(0, 8'h02); send(0, 8'h00); send(0, 8'h11);
    set_start(0, 1'b1);
    set_bypass(0, 1'b1);
    repeat (3) begin
      check("t3_gap_ready", a_if.in_ready, 1'b1);
      @(negedge clk);
    end
    set_start(0, 1'b0);
    set_bypass(0, 1'b0);
    send(0, 8'h22);
    repeat (2) @(negedge clk);
    check("t3_done", a_if.done, 1'b1);
    ea = {0, 1};
    ed = {8'h11, 8'h22};
    check_writes("t3", 0, ea, ed);

    for (int i = 0; i < 6; i++) run_load(0, $urandom_range(24, 1), 3);

    // bypass from IDLE
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    wr_q.delete();
    set_bypass(0, 1'b1);
    @(negedge clk);
    set_bypass(0, 1'b0);
    check("byp_done", a_if.done, 1'b1);
    check("byp_hold", a_if.cpu_hold, 1'b0);
    @(negedge clk);
    check("byp_nowrites", wr_q.size(), 0);
    run_load(0, 5, 1);

    // asynchronous reset in the middle of a 4-byte payload
    wr_q.delete();
    pulse_start(0);
    p0 = 8'($urandom);
    p1 = 8'($urandom);
    send(0, 8'h04); send(0, 8'h00); send(0, p0); send(0, p1);
    check("abort_pre_we", a_if.ram_we, 1'b1);
    #1 rst_a = 1'b1;
    #1;
    check("abort_we", a_if.ram_we, 1'b0);
    check("abort_ready", a_if.in_ready, 1'b0);
    check("abort_hold", a_if.cpu_hold, 1'b1);
    check("abort_addr", a_if.ram_addr, 16'h0000);
    check("abort_wdata", a_if.ram_wdata, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    ea = {0, 1};
    ed = {int'(p0), int'(p1)};
    check_writes("abort", 0, ea, ed);
    run_load(0, 3, 1);

    // ORIGIN = FFF0: overflow by one, then exactly filling the top
    run_load(1, 17, 0);
    pulse_start(1);
    @(negedge clk);
    check("err_sticky", b_if.error, 1'b1);
    check("err_ready", b_if.in_ready, 1'b0);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    run_load(1, 16, 1);
    for (int i = 0; i < 4; i++) begin
      rst_b = 1'b1;
      @(negedge clk);
      rst_b = 1'b0;
      run_load(1, $urandom_range(20, 0), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
